// File: rtl/param_processor.sv
// param_processor: small parameterised multi-cycle core.
// Programs are loaded into IMEM through the load port while IDLE. Each
// instruction then takes two cycles: FETCH latches IMEM[pc] into IR, and
// EXEC decodes IR and commits its result. A debug port reads the register
// file combinationally.
module param_processor #(
  parameter  int DATA_W  = 8,
  parameter  int RSEL_W  = 2,
  parameter  int ADDR_W  = 4,
  localparam int INSTR_W = 3 + 3*RSEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic [RSEL_W-1:0]  dbg_sel,
  output logic [DATA_W-1:0]  dbg_data,
  output logic [ADDR_W-1:0]  pc,
  output logic [DATA_W-1:0]  alu_out,
  output logic               zero,
  output logic               busy,
  output logic               halted,
  output logic               retire
);

  localparam int NREG   = 1 << RSEL_W;
  localparam int IMEM_D = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE, S_FETCH, S_EXEC, S_HALTED
  } state_t;

  typedef enum logic [2:0] {
    OP_HALT = 3'b000,
    OP_ADD  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_SUB  = 3'b100,
    OP_LDI  = 3'b101,
    OP_JMP  = 3'b110,
    OP_JZ   = 3'b111
  } op_t;

  // Field layout of one instruction word, rd in the LSBs.
  typedef struct packed {
    op_t               op;
    logic [RSEL_W-1:0] rs1;
    logic [RSEL_W-1:0] rs2;
    logic [RSEL_W-1:0] rd;
  } instr_t;

  state_t                       state_q, state_d;
  instr_t                       ir_q;
  logic [INSTR_W-1:0]           imem [IMEM_D];
  logic [NREG-1:0][DATA_W-1:0]  regs_q;
  logic [ADDR_W-1:0]            pc_q;
  logic [DATA_W-1:0]            alu_q;
  logic                         zero_q;

  logic [DATA_W-1:0]            op_a, op_b, imm, res;
  logic [ADDR_W-1:0]            tgt, pc_inc;
  logic                         wr_en;

  assign dbg_data = regs_q[dbg_sel];
  assign pc       = pc_q;
  assign alu_out  = alu_q;
  assign zero     = zero_q;

  // Operand fetch and immediate/target extraction. Casts zero-extend or
  // truncate so any legal parameter combination lines up.
  assign op_a   = regs_q[ir_q.rs1];
  assign op_b   = regs_q[ir_q.rs2];
  assign imm    = DATA_W'({ir_q.rs1, ir_q.rs2});
  assign tgt    = ADDR_W'({ir_q.rs1, ir_q.rs2, ir_q.rd});
  assign pc_inc = pc_q + ADDR_W'(1);

  // Result mux for the register-writing opcodes; arithmetic wraps.
  always_comb begin
    res   = '0;
    wr_en = 1'b0;
    case (ir_q.op)
      OP_ADD: begin res = op_a + op_b; wr_en = 1'b1; end
      OP_AND: begin res = op_a & op_b; wr_en = 1'b1; end
      OP_OR:  begin res = op_a | op_b; wr_en = 1'b1; end
      OP_SUB: begin res = op_a - op_b; wr_en = 1'b1; end
      OP_LDI: begin res = imm;         wr_en = 1'b1; end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and status outputs. A fetched instruction always executes;
  // run is only sampled at the end of EXEC so dropping it never splits one.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    halted  = 1'b0;
    retire  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        busy    = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        busy   = 1'b1;
        retire = 1'b1;
        if (ir_q.op == OP_HALT) state_d = S_HALTED;
        else if (!run)          state_d = S_IDLE;
        else                    state_d = S_FETCH;
      end
      S_HALTED: begin
        halted = 1'b1;
        if (!run) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Architectural state: pc, IR, register file, alu_out and zero flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= '0;
      ir_q   <= '0;
      regs_q <= '0;
      alu_q  <= '0;
      zero_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run) pc_q <= '0;
        end
        S_FETCH: begin
          ir_q <= instr_t'(imem[pc_q]);
        end
        S_EXEC: begin
          if (wr_en) begin
            regs_q[ir_q.rd] <= res;
            alu_q           <= res;
            zero_q          <= (res == '0);
            pc_q            <= pc_inc;
          end else if (ir_q.op == OP_JMP) begin
            pc_q <= tgt;
          end else if (ir_q.op == OP_JZ) begin
            pc_q <= zero_q ? tgt : pc_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // Program memory: written only while IDLE, never cleared by reset.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && prog_we) imem[prog_addr] <= prog_data;
  end

endmodule

// File: tb/tb_param_processor.sv
// Bench for param_processor: table of small programs with expected final
// state (scoreboarded), plus hand sequences for run-drop, prog_we while
// busy, reset mid-EXEC and a wide parameter instance.
module tb_param_processor;

  logic        clk = 1'b0;
  logic        rst;
  logic        run, prog_we;
  logic [3:0]  prog_addr;
  logic [8:0]  prog_data;
  logic [1:0]  dbg_sel;
  logic [7:0]  dbg_data, alu_out;
  logic [3:0]  pc;
  logic        zero, busy, halted, retire;

  logic        w_run, w_prog_we;
  logic [5:0]  w_prog_addr;
  logic [11:0] w_prog_data;
  logic [2:0]  w_dbg_sel;
  logic [15:0] w_dbg_data, w_alu_out;
  logic [5:0]  w_pc;
  logic        w_zero, w_busy, w_halted, w_retire;

  int n_chk = 0;
  int n_fail = 0;
  int nret = 0;
  int wret = 0;

  always #5 clk = ~clk;

  param_processor u_dut (
    .clk(clk), .rst(rst), .run(run), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .dbg_sel(dbg_sel),
    .dbg_data(dbg_data), .pc(pc), .alu_out(alu_out), .zero(zero),
    .busy(busy), .halted(halted), .retire(retire)
  );

  param_processor #(.DATA_W(16), .RSEL_W(3), .ADDR_W(6)) u_wide (
    .clk(clk), .rst(rst), .run(w_run), .prog_we(w_prog_we),
    .prog_addr(w_prog_addr), .prog_data(w_prog_data), .dbg_sel(w_dbg_sel),
    .dbg_data(w_dbg_data), .pc(w_pc), .alu_out(w_alu_out), .zero(w_zero),
    .busy(w_busy), .halted(w_halted), .retire(w_retire)
  );

  typedef struct packed {
    logic [15:0][8:0] prog;
    logic [7:0]       alu;
    logic             zero;
    logic [1:0]       sel;
    logic [7:0]       dval;
    logic [3:0]       pc;
    logic [7:0]       nret;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];
  vec_t exp_q [$];

  function automatic logic [8:0] ldi(int rd, int imm);
    return {3'b101, 4'(imm), 2'(rd)};
  endfunction
  function automatic logic [8:0] alu(logic [2:0] op, int a, int b, int d);
    return {op, 2'(a), 2'(b), 2'(d)};
  endfunction
  function automatic logic [8:0] br(logic [2:0] op, int t);
    return {op, 2'b00, 4'(t)};
  endfunction
  function automatic logic [11:0] wldi(int rd, int imm);
    return {3'b101, 6'(imm), 3'(rd)};
  endfunction
  function automatic logic [11:0] walu(logic [2:0] op, int a, int b, int d);
    return {op, 3'(a), 3'(b), 3'(d)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    if (retire)   nret++;
    if (w_retire) wret++;
  endtask

  task automatic do_reset();
    run = 0; w_run = 0; prog_we = 0; w_prog_we = 0;
    rst = 1;
    cycle();
    cycle();
    rst = 0;
    cycle();
  endtask

  task automatic load(input logic [15:0][8:0] p);
    for (int i = 0; i < 16; i++) begin
      prog_we = 1; prog_addr = 4'(i); prog_data = p[i];
      cycle();
    end
    prog_we = 0;
  endtask

  task automatic wait_halt(input string name);
    for (int k = 0; k < 100 && !halted; k++) cycle();
    chk(name, {31'b0, halted}, 32'd1);
  endtask

  initial begin
    vec_t e;
    rst = 1; run = 0; prog_we = 0; prog_addr = '0; prog_data = '0; dbg_sel = '0;
    w_run = 0; w_prog_we = 0; w_prog_addr = '0; w_prog_data = '0; w_dbg_sel = '0;

    for (int i = 0; i < NV; i++) vecs[i] = '0;
    // 0: LDI/LDI/ADD/HALT
    vecs[0].prog[0] = ldi(1, 5); vecs[0].prog[1] = ldi(2, 3); vecs[0].prog[2] = alu(3'b001, 1, 2, 3);
    vecs[0].alu = 8'h08; vecs[0].zero = 0; vecs[0].sel = 3; vecs[0].dval = 8'h08; vecs[0].pc = 3; vecs[0].nret = 4;
    // 1: SUB 3-5 wraps
    vecs[1].prog[0] = ldi(1, 5); vecs[1].prog[1] = ldi(2, 3); vecs[1].prog[2] = alu(3'b100, 2, 1, 3);
    vecs[1].alu = 8'hFE; vecs[1].zero = 0; vecs[1].sel = 3; vecs[1].dval = 8'hFE; vecs[1].pc = 3; vecs[1].nret = 4;
    // 2: SUB r1-r1 = 0
    vecs[2].prog[0] = ldi(1, 5); vecs[2].prog[1] = alu(3'b100, 1, 1, 3);
    vecs[2].alu = 8'h00; vecs[2].zero = 1; vecs[2].sel = 3; vecs[2].dval = 8'h00; vecs[2].pc = 2; vecs[2].nret = 3;
    // 3: 0xFE built by 0-2, then +3 wraps to 1
    vecs[3].prog[0] = ldi(1, 2); vecs[3].prog[1] = alu(3'b100, 0, 1, 1);
    vecs[3].prog[2] = ldi(2, 3); vecs[3].prog[3] = alu(3'b001, 1, 2, 3);
    vecs[3].alu = 8'h01; vecs[3].zero = 0; vecs[3].sel = 3; vecs[3].dval = 8'h01; vecs[3].pc = 4; vecs[3].nret = 5;
    // 4: AND 0x0C & 0x03
    vecs[4].prog[0] = ldi(1, 12); vecs[4].prog[1] = ldi(2, 3); vecs[4].prog[2] = alu(3'b010, 1, 2, 3);
    vecs[4].alu = 8'h00; vecs[4].zero = 1; vecs[4].sel = 3; vecs[4].dval = 8'h00; vecs[4].pc = 3; vecs[4].nret = 4;
    // 5: OR 0x0C | 0x03
    vecs[5].prog[0] = ldi(1, 12); vecs[5].prog[1] = ldi(2, 3); vecs[5].prog[2] = alu(3'b011, 1, 2, 3);
    vecs[5].alu = 8'h0F; vecs[5].zero = 0; vecs[5].sel = 3; vecs[5].dval = 8'h0F; vecs[5].pc = 3; vecs[5].nret = 4;
    // 6: JZ taken to 9
    vecs[6].prog[0] = ldi(1, 0); vecs[6].prog[1] = br(3'b111, 9);
    vecs[6].prog[9] = ldi(2, 7);
    vecs[6].alu = 8'h07; vecs[6].zero = 0; vecs[6].sel = 2; vecs[6].dval = 8'h07; vecs[6].pc = 10; vecs[6].nret = 4;
    // 7: JZ not taken
    vecs[7].prog[0] = ldi(1, 1); vecs[7].prog[1] = br(3'b111, 9); vecs[7].prog[2] = ldi(2, 4);
    vecs[7].prog[9] = ldi(2, 7);
    vecs[7].alu = 8'h04; vecs[7].zero = 0; vecs[7].sel = 2; vecs[7].dval = 8'h04; vecs[7].pc = 3; vecs[7].nret = 4;
    // 8: JMP to 15, sequential wrap to 0, JZ exits to HALT at 4
    vecs[8].prog[0] = br(3'b111, 4); vecs[8].prog[1] = ldi(1, 6); vecs[8].prog[2] = br(3'b110, 15);
    vecs[8].prog[15] = alu(3'b100, 1, 1, 3);
    vecs[8].alu = 8'h00; vecs[8].zero = 1; vecs[8].sel = 1; vecs[8].dval = 8'h06; vecs[8].pc = 4; vecs[8].nret = 6;
    // 9: rs1==rs2==rd
    vecs[9].prog[0] = ldi(1, 5); vecs[9].prog[1] = alu(3'b001, 1, 1, 1);
    vecs[9].alu = 8'h0A; vecs[9].zero = 0; vecs[9].sel = 1; vecs[9].dval = 8'h0A; vecs[9].pc = 2; vecs[9].nret = 3;

    // Reset state
    do_reset();
    chk("rst_alu", 32'(alu_out), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_zero", 32'(zero), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_retire", 32'(retire), 0);
    for (int r = 0; r < 4; r++) begin
      dbg_sel = 2'(r); #1;
      chk("rst_reg", 32'(dbg_data), 0);
    end

    // Table-driven programs, scoreboarded
    for (int i = 0; i < NV; i++) begin
      do_reset();
      load(vecs[i].prog);
      dbg_sel = vecs[i].sel;
      nret = 0;
      run = 1;
      exp_q.push_back(vecs[i]);
      wait_halt("vec_halt");
      chk("sb_depth", 32'(exp_q.size()), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("vec_alu", 32'(alu_out), 32'(e.alu));
        chk("vec_zero", 32'(zero), 32'(e.zero));
        chk("vec_dbg", 32'(dbg_data), 32'(e.dval));
        chk("vec_pc", 32'(pc), 32'(e.pc));
        chk("vec_nret", 32'(nret), 32'(e.nret));
        chk("vec_busy", 32'(busy), 0);
      end
      run = 0;
      cycle();
      chk("vec_idle_halted", 32'(halted), 0);
    end

    // prog_we while busy must not alter IMEM; re-run reads it back
    do_reset();
    load(vecs[0].prog);
    nret = 0; run = 1;
    cycle(); cycle();
    chk("we_busy", 32'(busy), 1);
    prog_we = 1; prog_addr = 4'd2; prog_data = 9'h000;
    cycle();
    prog_we = 0;
    wait_halt("we_halt1");
    chk("we_alu1", 32'(alu_out), 8'h08);
    run = 0; cycle();
    nret = 0; run = 1;
    wait_halt("we_halt2");
    chk("we_alu2", 32'(alu_out), 8'h08);
    chk("we_pc2", 32'(pc), 3);
    chk("we_nret2", 32'(nret), 4);
    run = 0; cycle();

    // run dropped during EXEC of first instruction
    do_reset();
    load(vecs[0].prog);
    nret = 0; run = 1;
    for (int k = 0; k < 20 && !retire; k++) cycle();
    chk("drop_exec_seen", 32'(retire), 1);
    run = 0;
    cycle();
    chk("drop_busy", 32'(busy), 0);
    chk("drop_halted", 32'(halted), 0);
    chk("drop_pc", 32'(pc), 1);
    chk("drop_nret", 32'(nret), 1);
    dbg_sel = 1; #1;
    chk("drop_r1", 32'(dbg_data), 5);
    dbg_sel = 2; #1;
    chk("drop_r2", 32'(dbg_data), 0);
    cycle(); cycle();
    chk("drop_stays_idle", 32'(busy), 0);

    // Reset asserted during EXEC of the ADD
    do_reset();
    load(vecs[0].prog);
    nret = 0; run = 1;
    for (int k = 0; k < 30 && !(retire && pc == 4'd2); k++) cycle();
    chk("rstx_in_add", 32'(retire && pc == 4'd2), 1);
    #2 rst = 1;
    #1;
    chk("rstx_alu", 32'(alu_out), 0);
    chk("rstx_pc", 32'(pc), 0);
    chk("rstx_busy", 32'(busy), 0);
    chk("rstx_retire", 32'(retire), 0);
    dbg_sel = 3; #1;
    chk("rstx_r3", 32'(dbg_data), 0);
    dbg_sel = 1; #1;
    chk("rstx_r1", 32'(dbg_data), 0);
    #2 rst = 0;
    nret = 0;
    dbg_sel = 3;
    wait_halt("rstx_rerun_halt");
    chk("rstx_rerun_r3", 32'(dbg_data), 8'h08);
    chk("rstx_rerun_nret", 32'(nret), 4);
    run = 0; cycle();

    // Wide instance: DATA_W=16, RSEL_W=3, ADDR_W=6
    do_reset();
    begin
      logic [11:0] wp [5];
      wp[0] = wldi(1, 5); wp[1] = wldi(2, 3); wp[2] = walu(3'b001, 1, 2, 3);
      wp[3] = walu(3'b100, 2, 1, 4); wp[4] = 12'h000;
      for (int i = 0; i < 5; i++) begin
        w_prog_we = 1; w_prog_addr = 6'(i); w_prog_data = wp[i];
        cycle();
      end
      w_prog_we = 0;
    end
    wret = 0; w_run = 1;
    for (int k = 0; k < 100 && !w_halted; k++) cycle();
    chk("wide_halt", 32'(w_halted), 1);
    chk("wide_alu", 32'(w_alu_out), 16'hFFFE);
    chk("wide_pc", 32'(w_pc), 4);
    chk("wide_nret", 32'(wret), 5);
    w_dbg_sel = 3; #1;
    chk("wide_r3", 32'(w_dbg_data), 16'h0008);
    w_dbg_sel = 4; #1;
    chk("wide_r4", 32'(w_dbg_data), 16'hFFFE);
    w_run = 0; cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
